core_mem_scheduler: RTL
=======================

Name: core_mem_scheduler

Overview:
- Sequences a cluster of NUM_CORES processor cores and round-robin arbitrates their data-memory writes onto one shared single-port data memory.
- Drives each core's 2-bit status input, collects each core's end_process, and raises done when every core has finished and no write is pending.
- Sits at cluster top level, between the core array and the shared data memory.

Parameters:
- NUM_CORES, 4, number of cores arbitrated (2..8).
- AW, 16, data-memory address width.
- DW, 16, data-memory word width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that launches all cores.
- core_wr_req  in  NUM_CORES  per-core DM_write_en.
- core_addr  in  NUM_CORES*AW  per-core AR_out, packed with core i at bits [i*AW +: AW].
- core_wdata  in  NUM_CORES*DW  per-core bus value, packed the same way.
- core_end  in  NUM_CORES  per-core end_process.
- core_status  out  NUM_CORES*2  per-core status, packed with core i at [2i+1:2i].
- dm_we  out  1  shared memory write enable.
- dm_addr  out  AW  shared memory address.
- dm_wdata  out  DW  shared memory write data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.

Behaviour:
- Status encoding (shared package): 2'b00 HOLD (core frozen), 2'b01 RUN, 2'b10 STALL (write pending, core must keep request, address and data stable), 2'b11 FIN.
- Reset (rst_n=0 at a clk edge), all registered:
  - FSM goes to IDLE; every status is HOLD.
  - dm_we=0, dm_addr=0, dm_wdata=0; busy=0, done=0.
  - Round-robin pointer = 0; sticky end flags cleared.
  - Reset mid-operation abandons any pending write without issuing it.
- FSM:
  - IDLE: start=1 -> RUN. Every status becomes RUN on the next cycle.
  - RUN: on each core_end[i]=1, sticky fin[i] is set and status[i]=FIN from the next cycle. FIN is final until reset or a new start from DONE. When all fin bits are set -> DRAIN.
  - DRAIN: one cycle to let the final registered write retire -> DONE.
  - DONE: done=1, dm_we=0. start=1 -> RUN with fin cleared. start is ignored in RUN and DRAIN.
- Arbitration:
  - Evaluated in RUN only, and only for cores whose fin bit is clear.
  - Each cycle, at most one requester is granted. Search starts at the pointer and wraps modulo NUM_CORES.
  - Granted core g: dm_we/dm_addr/dm_wdata take g's request on the next edge (1-cycle latency); pointer becomes (g+1) mod NUM_CORES; status[g]=RUN next cycle.
  - Any non-granted requester: status=STALL from the next cycle until the cycle after its grant.
  - No requester: dm_we=0 next cycle, pointer unchanged.
  - Fairness: a continuously requesting core is granted within NUM_CORES cycles.
- Simultaneous core_end and core_wr_req from the same core in one cycle: the write is arbitrated normally and fin is set in parallel. If granted, the write completes; if not granted, the write is dropped and status goes straight to FIN.
- dm_addr and dm_wdata hold their last value when dm_we=0.

Optional Feature:
- Macro: CORE_MEM_SCHED_STATS_EN.
- With it: adds output wr_count (NUM_CORES*16). It holds one saturating count per core of granted writes (saturates at 16'hFFFF), cleared by reset and by start.
- Without it: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Package core_mem_sched_pkg holds the status encodings (ST_HOLD, ST_RUN, ST_STALL, ST_FIN) and the FSM state typedef (IDLE, RUN, DRAIN, DONE).
- One sub-module, rr_arbiter, parameterised by width: inputs req and pointer; outputs one-hot grant, grant index and valid. It is purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset then start, NUM_CORES=4, no requests -> cycle after start all status=01, busy=1, dm_we=0.
- Cores 0 and 2 request together (addr 0x10 and 0x20, pointer 0) -> cycle+1: dm_we=1, dm_addr=0x10, status2=10. Cycle+2: dm_addr=0x20, status2=01.
- All four cores request continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; no core stalls more than 3 consecutive cycles.
- core_end asserted on cores 3,1,0,2 on different cycles -> each status=11 the next cycle; DRAIN one cycle after the last; then done=1, busy=0.
- rst_n=0 while core 1 is in STALL -> next cycle all status=00, dm_we=0, and the pending write is never issued.
- With CORE_MEM_SCHED_STATS_EN: core 0 granted 5 writes -> wr_count[15:0]=5; a new start clears it to 0.

Source files
------------

// File: rtl/core_mem_scheduler_pkg.sv
// Shared encodings for the core cluster scheduler: per-core status codes and FSM states.
// Latency: n/a (types only). Backpressure: n/a.
// Imported by core_mem_scheduler and the testbench.
package core_mem_sched_pkg;

    localparam logic [1:0] ST_HOLD  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STALL = 2'b10;
    localparam logic [1:0] ST_FIN   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/core_mem_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after pointer, wrapping modulo N.
// Latency: purely combinational. Backpressure: none; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(pointer) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = IW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_mem_scheduler.sv
// Sequences NUM_CORES cores and round-robin arbitrates their writes onto one shared data memory.
// Latency: granted write appears on dm_* one cycle after the request; status updates one cycle after its cause.
// Backpressure: losing requesters see STALL and must hold request/addr/data; CORE_MEM_SCHED_STATS_EN adds wr_count.
module core_mem_scheduler
    import core_mem_sched_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int AW        = 16,
    parameter int DW        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_CORES-1:0]    core_wr_req,
    input  logic [NUM_CORES*AW-1:0] core_addr,
    input  logic [NUM_CORES*DW-1:0] core_wdata,
    input  logic [NUM_CORES-1:0]    core_end,
    output logic [NUM_CORES*2-1:0]  core_status,
`ifdef CORE_MEM_SCHED_STATS_EN
    output logic [NUM_CORES*16-1:0] wr_count,
`endif
    output logic                    dm_we,
    output logic [AW-1:0]           dm_addr,
    output logic [DW-1:0]           dm_wdata,
    output logic                    busy,
    output logic                    done
);

    localparam int IW = $clog2(NUM_CORES);

    sched_state_t                  state_q, state_nxt;
    logic [NUM_CORES-1:0]          fin_q, fin_nxt;
    logic [NUM_CORES-1:0][1:0]     status_q, status_nxt;
    logic [IW-1:0]                 ptr_q;

    logic [NUM_CORES-1:0]          arb_req;
    logic [NUM_CORES-1:0]          grant;
    logic [IW-1:0]                 grant_idx;
    logic                          grant_vld;
    logic                          launch;

    logic [NUM_CORES-1:0][AW-1:0]  addr_arr;
    logic [NUM_CORES-1:0][DW-1:0]  data_arr;

    assign addr_arr    = core_addr;
    assign data_arr    = core_wdata;
    assign core_status = status_q;

    // Finished cores are invisible to the arbiter; outside RUN nobody is eligible.
    assign arb_req = (state_q == RUN) ? (core_wr_req & ~fin_q) : '0;
    assign launch  = start && ((state_q == IDLE) || (state_q == DONE));

    rr_arbiter #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_arb (
        .req       (arb_req),
        .pointer   (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        state_nxt  = state_q;
        fin_nxt    = fin_q;
        status_nxt = status_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_nxt  = RUN;
                    fin_nxt    = '0;
                    status_nxt = {NUM_CORES{ST_RUN}};
                end
            end
            RUN: begin
                fin_nxt = fin_q | core_end;
                for (int i = 0; i < NUM_CORES; i++) begin
                    // A core ending while losing arbitration drops its write and goes straight to FIN.
                    if (fin_nxt[i])
                        status_nxt[i] = ST_FIN;
                    else if (core_wr_req[i] && !grant[i])
                        status_nxt[i] = ST_STALL;
                    else
                        status_nxt[i] = ST_RUN;
                end
                if (&fin_nxt) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fin_q    <= '0;
            status_q <= {NUM_CORES{ST_HOLD}};
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            fin_q    <= fin_nxt;
            status_q <= status_nxt;
            busy     <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done     <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            ptr_q    <= '0;
        end else begin
            dm_we <= grant_vld;
            if (grant_vld) begin
                dm_addr  <= addr_arr[grant_idx];
                dm_wdata <= data_arr[grant_idx];
                ptr_q    <= (grant_idx == IW'(NUM_CORES - 1)) ? '0 : grant_idx + IW'(1);
            end
        end
    end

`ifdef CORE_MEM_SCHED_STATS_EN
    logic [NUM_CORES-1:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || launch) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (grant[i] && (cnt_q[i] != 16'hFFFF))
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    assign wr_count = cnt_q;
`endif

endmodule
